// File: rtl/ctrl_time_sched_8_pkg.sv
// Shared widths and commit-FSM state codes for the switching-time scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
// Used by ctrl_time_sched_8 and its time bank.
package ctrl_time_sched_8_pkg;

  localparam int CTRL_CW    = 12;
  localparam int CTRL_NEV   = 8;
  localparam int CTRL_IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } sched_st_e;

endpackage

// File: rtl/ctrl_time_sched_8_bank.sv
// Time bank: shadow and active event tables, each slot {value, time}.
// Latency: a write lands in shadow one cycle later; load copies shadow into active one cycle later.
// Backpressure: none; writes are always accepted, and a load copies the shadow as it stood before that cycle's write.
module ctrl_time_sched_8_bank
  import ctrl_time_sched_8_pkg::*;
#(
  parameter int CW  = CTRL_CW,
  parameter int NEV = CTRL_NEV
) (
  input  logic                  clk,
  input  logic                  sta,
  input  logic                  wr_en,
  input  logic [CTRL_IDX_W-1:0] wr_idx,
  input  logic [CW-1:0]         wr_time,
  input  logic                  wr_value,
  input  logic                  load,
  output logic [NEV-1:0][CW:0]  shadow,
  output logic [NEV-1:0][CW:0]  active
);

  logic [NEV-1:0][CW:0] shadow_q, shadow_d;
  logic [NEV-1:0][CW:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en) begin
      shadow_d[wr_idx] = {wr_value, wr_time};
    end
    active_d = load ? shadow_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (sta) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign shadow = shadow_q;
  assign active = active_q;

endmodule

// File: rtl/ctrl_time_sched_8.sv
// Step counter plus double-buffered 8-event table; commits swap in only at a period wrap.
// Latency: all outputs registered, one cycle after their cause. Backpressure: commit while pending is ignored.
// Optional CTRL_TIME_SORT_CHECK_EN: reject unsorted or out-of-range tables at load with a cfg_err pulse.
module ctrl_time_sched_8
  import ctrl_time_sched_8_pkg::*;
#(
  parameter int            CW      = CTRL_CW,
  parameter logic [CW-1:0] PER_RST = '0
) (
  input  logic                  clk,
  input  logic                  sta,
  input  logic [CW-1:0]         period,
  input  logic                  wr_en,
  input  logic [CTRL_IDX_W-1:0] wr_idx,
  input  logic [CW-1:0]         wr_time,
  input  logic                  wr_value,
  input  logic                  commit,
  output logic                  pending,
  output logic                  wrap,
  output logic [CW-1:0]         counter,
  output logic [CW-1:0]         time_1,
  output logic [CW-1:0]         time_2,
  output logic [CW-1:0]         time_3,
  output logic [CW-1:0]         time_4,
  output logic [CW-1:0]         time_5,
  output logic [CW-1:0]         time_6,
  output logic [CW-1:0]         time_7,
  output logic [CW-1:0]         time_8,
  output logic                  value_1,
  output logic                  value_2,
  output logic                  value_3,
  output logic                  value_4,
  output logic                  value_5,
  output logic                  value_6,
  output logic                  value_7,
  output logic                  value_8,
  output logic                  cfg_err
);

  localparam int NEV = CTRL_NEV;

  sched_st_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        per_q, per_d;
  logic [CW-1:0]        per_sh_q, per_sh_d;
  logic                 wrap_q, wrap_d;
  logic                 last_step, load_req, load;
  logic [NEV-1:0][CW:0] shadow, active;

  assign last_step = (per_q != '0) && (cnt_q == per_q - CW'(1));
  // A frozen counter (period 0) has no boundary to wait for, so any cycle is a boundary.
  assign load_req  = (state_q == ST_ARMED) && ((per_q == '0) || last_step);

`ifdef CTRL_TIME_SORT_CHECK_EN
  logic tbl_good, cfg_err_q, cfg_err_d;

  function automatic logic tbl_ok(input logic [NEV-1:0][CW:0] tbl, input logic [CW-1:0] per);
    logic          ok;
    logic          gap;
    logic [CW-1:0] prev;
    logic [CW-1:0] t;
    ok   = 1'b1;
    gap  = 1'b0;
    prev = '0;
    for (int i = 0; i < NEV; i++) begin
      t = tbl[i][CW-1:0];
      if (t == '0) begin
        gap = 1'b1;
      end else begin
        if (gap || (t <= prev) || (t > per)) ok = 1'b0;
        prev = t;
      end
    end
    return ok;
  endfunction

  assign tbl_good = tbl_ok(shadow, per_sh_q);
  assign load     = load_req && tbl_good;

  always_comb begin
    cfg_err_d = load_req && !tbl_good;
  end

  always_ff @(posedge clk) begin
    if (sta) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;
`else
  logic unused_shadow;
  assign unused_shadow = ^shadow;
  assign load          = load_req;
  assign cfg_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sta) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (commit)   state_d = ST_ARMED;
      ST_ARMED: if (load_req) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    per_sh_d = per_sh_q;
    if ((state_q == ST_IDLE) && commit) per_sh_d = period;
    per_d = load ? per_sh_q : per_q;
    if (per_q == '0) begin
      cnt_d  = '0;
      wrap_d = 1'b0;
    end else if (last_step) begin
      cnt_d  = '0;
      wrap_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sta) begin
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      per_q    <= PER_RST;
      per_sh_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      per_q    <= per_d;
      per_sh_q <= per_sh_d;
    end
  end

  ctrl_time_sched_8_bank #(.CW(CW), .NEV(NEV)) u_bank (
    .clk      (clk),
    .sta      (sta),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_time  (wr_time),
    .wr_value (wr_value),
    .load     (load),
    .shadow   (shadow),
    .active   (active)
  );

  assign pending = (state_q == ST_ARMED);
  assign wrap    = wrap_q;
  assign counter = cnt_q;
  assign time_1  = active[0][CW-1:0];
  assign time_2  = active[1][CW-1:0];
  assign time_3  = active[2][CW-1:0];
  assign time_4  = active[3][CW-1:0];
  assign time_5  = active[4][CW-1:0];
  assign time_6  = active[5][CW-1:0];
  assign time_7  = active[6][CW-1:0];
  assign time_8  = active[7][CW-1:0];
  assign value_1 = active[0][CW];
  assign value_2 = active[1][CW];
  assign value_3 = active[2][CW];
  assign value_4 = active[3][CW];
  assign value_5 = active[4][CW];
  assign value_6 = active[5][CW];
  assign value_7 = active[6][CW];
  assign value_8 = active[7][CW];

endmodule

// File: tb/tb_ctrl_time_sched_8.sv
// Bench for ctrl_time_sched_8: directed scenarios plus random traffic against a rule-level model.
module tb_ctrl_time_sched_8;

  logic        clk = 1'b0;
  logic        sta = 1'b1;
  logic [11:0] period = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [11:0] wr_time = '0;
  logic        wr_value = 1'b0;
  logic        commit = 1'b0;

  logic        pending, wrap, cfg_err;
  logic [11:0] counter;
  logic [11:0] time_1, time_2, time_3, time_4, time_5, time_6, time_7, time_8;
  logic        value_1, value_2, value_3, value_4, value_5, value_6, value_7, value_8;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_cnt = 0, m_per = 0, m_shper = 0;
  bit          m_pend = 0, m_wrap = 0, m_err = 0;
  logic [11:0] m_sh_t[8], m_act_t[8];
  logic        m_sh_v[8], m_act_v[8];

  ctrl_time_sched_8 dut (
    .clk(clk), .sta(sta), .period(period), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_time(wr_time), .wr_value(wr_value), .commit(commit),
    .pending(pending), .wrap(wrap), .counter(counter),
    .time_1(time_1), .time_2(time_2), .time_3(time_3), .time_4(time_4),
    .time_5(time_5), .time_6(time_6), .time_7(time_7), .time_8(time_8),
    .value_1(value_1), .value_2(value_2), .value_3(value_3), .value_4(value_4),
    .value_5(value_5), .value_6(value_6), .value_7(value_7), .value_8(value_8),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic bit tbl_ok_m();
`ifdef CTRL_TIME_SORT_CHECK_EN
    int q[$];
    for (int i = 0; i < 8; i++) if (m_sh_t[i] != 0) q.push_back(int'(m_sh_t[i]));
    for (int i = 0; i < q.size(); i++) if (m_sh_t[i] == 0) return 0;
    for (int i = 1; i < q.size(); i++) if (q[i] <= q[i-1]) return 0;
    foreach (q[i]) if (q[i] > m_shper) return 0;
    return 1;
`else
    return 1;
`endif
  endfunction

  function automatic void model_update();
    int nc;
    bit lr;
    if (sta) begin
      m_cnt = 0; m_per = 0; m_shper = 0; m_pend = 0; m_wrap = 0; m_err = 0;
      for (int i = 0; i < 8; i++) begin
        m_sh_t[i] = 0; m_sh_v[i] = 0; m_act_t[i] = 0; m_act_v[i] = 0;
      end
      return;
    end
    lr     = m_pend && (m_per == 0 || m_cnt == m_per - 1);
    nc     = (m_per == 0) ? 0 : (m_cnt + 1) % m_per;
    m_wrap = (m_per != 0) && (nc == 0);
    m_cnt  = nc;
    m_err  = 0;
    if (lr) begin
      if (tbl_ok_m()) begin
        for (int i = 0; i < 8; i++) begin
          m_act_t[i] = m_sh_t[i]; m_act_v[i] = m_sh_v[i];
        end
        m_per = m_shper;
      end else begin
        m_err = 1;
      end
      m_pend = 0;
    end else if (!m_pend && commit) begin
      m_pend  = 1;
      m_shper = int'(period);
    end
    if (wr_en) begin
      m_sh_t[wr_idx] = wr_time;
      m_sh_v[wr_idx] = wr_value;
    end
  endfunction

  function automatic logic [118:0] dv();
    logic [95:0] t;
    logic [7:0]  v;
    t = {time_8, time_7, time_6, time_5, time_4, time_3, time_2, time_1};
    v = {value_8, value_7, value_6, value_5, value_4, value_3, value_2, value_1};
    return {pending, wrap, cfg_err, counter, t, v};
  endfunction

  function automatic logic [118:0] mv();
    logic [95:0] t;
    logic [7:0]  v;
    for (int i = 0; i < 8; i++) begin
      t[i*12 +: 12] = m_act_t[i];
      v[i]          = m_act_v[i];
    end
    return {m_pend, m_wrap, m_err, 12'(m_cnt), t, v};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    sta = 0; wr_en = 0; commit = 0;
  endtask

  task automatic wr(input int idx, input int t, input bit v);
    wr_en = 1; wr_idx = 3'(idx); wr_time = 12'(t); wr_value = v;
  endtask

  task automatic wait_load();
    for (int k = 0; k < 40 && m_pend; k++) step();
  endtask

  task automatic test_reset();
    sta = 1; wr_en = 0; commit = 0;
    step(); step();
    quiet();
    checks++;
    if (dv() !== 119'd0) begin
      errors++; $display("FAIL reset_state: got %h want 0", dv());
    end
    step(); step();
    checks++;
    if (counter !== 12'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL reset_frozen: counter=%0d wrap=%b want 0/0", counter, wrap);
    end
  endtask

  task automatic test_basic();
    wr(0, 3, 1); step();
    wr(1, 6, 0); step();
    wr(2, 9, 1); commit = 1; period = 10; step();
    quiet();
    checks++;
    if (pending !== 1'b1 || counter !== 12'd0) begin
      errors++; $display("FAIL basic_pending: pending=%b counter=%0d want 1/0", pending, counter);
    end
    step();
    checks++;
    if (time_1 !== 12'd3 || value_1 !== 1'b1 || time_3 !== 12'd9 || pending !== 1'b0) begin
      errors++; $display("FAIL basic_load: t1=%0d v1=%b t3=%0d pend=%b want 3/1/9/0",
                         time_1, value_1, time_3, pending);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (counter !== 12'((k + 1) % 10) || wrap !== ((k + 1) % 10 == 0)) begin
        errors++; $display("FAIL basic_count: k=%0d counter=%0d wrap=%b", k, counter, wrap);
      end
      checks++;
      if (dv() !== mv()) begin
        errors++; $display("FAIL basic_model: got %h want %h", dv(), mv());
      end
    end
  endtask

  task automatic test_midperiod();
    for (int k = 0; k < 20 && m_cnt != 4; k++) step();
    wr(0, 5, 1); commit = 1; step();
    quiet();
    for (int k = 0; k < 20 && m_pend; k++) begin
      checks++;
      if (time_1 !== 12'd3) begin
        errors++; $display("FAIL mid_hold: time_1=%0d want 3", time_1);
      end
      step();
    end
    checks++;
    if (time_1 !== 12'd5 || counter !== 12'd0 || pending !== 1'b0 || wrap !== 1'b1) begin
      errors++; $display("FAIL mid_swap: t1=%0d cnt=%0d pend=%b wrap=%b want 5/0/0/1",
                         time_1, counter, pending, wrap);
    end
  endtask

  task automatic test_write_on_load();
    commit = 1; period = 10; step();
    quiet();
    for (int k = 0; k < 20 && !(m_pend && m_cnt == 9); k++) step();
    wr(1, 7, 1); step();
    quiet();
    checks++;
    if (time_2 !== 12'd6 || value_2 !== 1'b0 || pending !== 1'b0 || counter !== 12'd0) begin
      errors++; $display("FAIL wol_pre: t2=%0d v2=%b pend=%b cnt=%0d want 6/0/0/0",
                         time_2, value_2, pending, counter);
    end
    commit = 1; step();
    quiet();
    wait_load();
    checks++;
    if (time_2 !== 12'd7 || value_2 !== 1'b1) begin
      errors++; $display("FAIL wol_post: t2=%0d v2=%b want 7/1", time_2, value_2);
    end
  endtask

  task automatic test_period_edge();
    wr(0, 0, 0); step();
    wr(1, 0, 0); step();
    wr(2, 0, 0); commit = 1; period = 1; step();
    quiet();
    wait_load();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (counter !== 12'd0 || wrap !== 1'b1) begin
        errors++; $display("FAIL per1: counter=%0d wrap=%b want 0/1", counter, wrap);
      end
    end
    commit = 1; period = 0; step();
    quiet();
    wait_load();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (counter !== 12'd0 || wrap !== 1'b0 || dv() !== mv()) begin
        errors++; $display("FAIL per0: counter=%0d wrap=%b want 0/0", counter, wrap);
      end
    end
  endtask

  task automatic test_sort();
    wr(0, 2, 1); step();
    wr(1, 4, 0); commit = 1; period = 8; step();
    quiet();
    wait_load();
    wr(0, 6, 0); step();
    wr(1, 3, 1); commit = 1; period = 8; step();
    quiet();
    wait_load();
    checks++;
`ifdef CTRL_TIME_SORT_CHECK_EN
    if (cfg_err !== 1'b1 || time_1 !== 12'd2 || time_2 !== 12'd4) begin
      errors++; $display("FAIL sort_reject: err=%b t1=%0d t2=%0d want 1/2/4", cfg_err, time_1, time_2);
    end
`else
    if (cfg_err !== 1'b0 || time_1 !== 12'd6 || time_2 !== 12'd3) begin
      errors++; $display("FAIL sort_load: err=%b t1=%0d t2=%0d want 0/6/3", cfg_err, time_1, time_2);
    end
`endif
    step();
    checks++;
    if (cfg_err !== 1'b0 || pending !== 1'b0) begin
      errors++; $display("FAIL sort_pulse: err=%b pend=%b want 0/0", cfg_err, pending);
    end
  endtask

  task automatic test_sta_armed();
    wr(0, 1, 1); step();
    wr(1, 2, 0); commit = 1; period = 10; step();
    quiet();
    wait_load();
    commit = 1; step();
    quiet();
    for (int k = 0; k < 20 && m_cnt != 7; k++) step();
    checks++;
    if (pending !== 1'b1 || counter !== 12'd7) begin
      errors++; $display("FAIL sta_pre: pend=%b cnt=%0d want 1/7", pending, counter);
    end
    sta = 1; step();
    quiet();
    checks++;
    if (dv() !== 119'd0) begin
      errors++; $display("FAIL sta_armed: got %h want 0", dv());
    end
    step();
    checks++;
    if (counter !== 12'd0 || pending !== 1'b0 || time_1 !== 12'd0) begin
      errors++; $display("FAIL sta_after: cnt=%0d pend=%b t1=%0d want 0/0/0", counter, pending, time_1);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      sta      = ($urandom_range(0, 199) == 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_idx   = 3'($urandom_range(0, 7));
      wr_time  = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom_range(1, 14));
      wr_value = 1'($urandom_range(0, 1));
      commit   = ($urandom_range(0, 7) == 0);
      period   = 12'($urandom_range(0, 12));
      step();
      checks++;
      if (dv() !== mv()) begin
        errors++; $display("FAIL random_model: cycle=%0d got %h want %h", k, dv(), mv());
      end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midperiod();
    test_write_on_load();
    test_period_edge();
    test_sort();
    test_sta_armed();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
